// File: rtl/grf_write_port.sv
// grf_write_port: single GRF write port shared by two sources.
// A pipeline writeback always wins the port. Multiply/divide results wait in a
// small FIFO and drain on cycles with no writeback. A buffered entry whose
// destination gets a newer writeback is killed and later leaves as a bubble.
// The hazard unit can ask whether a register still has a live buffered write.
module grf_write_port #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [31:0] mdu_pc,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q1_busy,
  output logic        q2_busy,
  output logic [4:0]  A3,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic [31:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // FIFO storage, one slot per entry
  logic [DEPTH-1:0] live_r;
  logic [4:0]       addr_r [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [31:0]      pc_r   [DEPTH];

  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;

  // Output register
  logic [4:0]       a3_r;
  logic [31:0]      write_data_r;
  logic             reg_write_r;
  logic [31:0]      pc_out_r;

  // Per-cycle control
  logic             wb_slot_s;
  logic             mdu_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             head_live_s;
  logic [DEPTH-1:0] in_range_s;
  logic [DEPTH-1:0] kill_s;
  logic             q1_busy_s;
  logic             q2_busy_s;

  // Arbitration: writeback owns the port, otherwise the FIFO head drains.
  // Readiness comes from the registered count, so a full FIFO refuses a push
  // even on the cycle it pops.
  always_comb begin
    wb_slot_s   = 1'b0;
    mdu_ready_s = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    head_live_s = live_r[rd_ptr_r];
    if (wb_we && (wb_addr != 5'd0)) begin
      wb_slot_s = 1'b1;
    end else begin
      wb_slot_s = 1'b0;
    end
    if (count_r < DEPTH_C) begin
      mdu_ready_s = 1'b1;
    end else begin
      mdu_ready_s = 1'b0;
    end
    // A handshake to $0 completes but stores nothing
    if (mdu_valid && mdu_ready_s && (mdu_addr != 5'd0)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
    if (!wb_slot_s && (count_r != {CW{1'b0}})) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Occupancy per physical slot: distance from the read pointer below count
  always_comb begin
    in_range_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      in_range_s[i] = ({1'b0, (AW'(i) - rd_ptr_r)} < count_r);
    end
  end

  // Kill mask: a writeback supersedes every older buffered write to its register
  always_comb begin
    kill_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      kill_s[i] = wb_slot_s && (addr_r[i] == wb_addr);
    end
  end

  // Scoreboard: a query hits when a live occupied entry targets that nonzero register
  always_comb begin
    q1_busy_s = 1'b0;
    q2_busy_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      q1_busy_s = q1_busy_s | (in_range_s[i] && live_r[i] &&
                               (addr_r[i] == q1_addr) && (q1_addr != 5'd0));
      q2_busy_s = q2_busy_s | (in_range_s[i] && live_r[i] &&
                               (addr_r[i] == q2_addr) && (q2_addr != 5'd0));
    end
  end

  // FIFO state: kills, pop, push and occupancy count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_r   <= {DEPTH{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= 5'd0;
        data_r[i] <= 32'd0;
        pc_r[i]   <= 32'd0;
      end
    end else begin
      // Kills apply only to entries already stored; a same-edge push is
      // written afterwards and is younger than the writeback.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_s[i]) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        live_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r         <= rd_ptr_r + AW'(1);
      end
      if (push_s) begin
        live_r[wr_ptr_r] <= 1'b1;
        addr_r[wr_ptr_r] <= mdu_addr;
        data_r[wr_ptr_r] <= mdu_data;
        pc_r[wr_ptr_r]   <= mdu_pc;
        wr_ptr_r         <= wr_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output register: writeback, else live head, else bubble holding old fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_r         <= 5'd0;
      write_data_r <= 32'd0;
      reg_write_r  <= 1'b0;
      pc_out_r     <= 32'd0;
    end else if (wb_slot_s) begin
      a3_r         <= wb_addr;
      write_data_r <= wb_data;
      reg_write_r  <= 1'b1;
      pc_out_r     <= wb_pc;
    end else if (pop_s && head_live_s) begin
      a3_r         <= addr_r[rd_ptr_r];
      write_data_r <= data_r[rd_ptr_r];
      reg_write_r  <= 1'b1;
      pc_out_r     <= pc_r[rd_ptr_r];
    end else begin
      reg_write_r  <= 1'b0;
    end
  end

  assign mdu_ready = mdu_ready_s;
  assign q1_busy   = q1_busy_s;
  assign q2_busy   = q2_busy_s;
  assign A3        = a3_r;
  assign WriteData = write_data_r;
  assign RegWrite  = reg_write_r;
  assign pc        = pc_out_r;

endmodule

// File: doc/grf_write_port.md
# grf_write_port

Write-side front end for the general register file. Merges the pipeline writeback stream and the multi-cycle multiply/divide (MDU) result stream into the single GRF write port (address, data, enable, pc). Pipeline writes have absolute priority. MDU results are buffered in a small FIFO, and stale buffered writes are cancelled. A pending-write scoreboard is exported to the hazard unit.

## Interface
- DEPTH, 4, MDU write FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- wb_we  in  1  pipeline writeback request this cycle (never stalled)
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- wb_pc  in  32  pc of the writing instruction
- mdu_valid  in  1  MDU result offered
- mdu_ready  out  1  FIFO can accept; equals (count < DEPTH) from registered count
- mdu_addr  in  5  MDU destination register
- mdu_data  in  32  MDU result
- mdu_pc  in  32  pc of the MDU instruction
- q1_addr, q2_addr  in  5 each  hazard query addresses
- q1_busy, q2_busy  out  1 each  a live FIFO entry targets that nonzero address (combinational)
- A3  out  5  GRF write address (registered)
- WriteData  out  32  GRF write data (registered)
- RegWrite  out  1  GRF write enable (registered)
- pc  out  32  pc forwarded to GRF write log (registered)

## Operation
- FIFO entry fields: live bit, addr[4:0], data[31:0], pc[31:0]. Read pointer, write pointer, and count are sized for DEPTH and wrap modulo DEPTH.
- MDU push when mdu_valid && mdu_ready.
  - mdu_addr==0: handshake completes, nothing is stored, and count is unchanged.
  - Otherwise, store the entry with live=1.
- WB slot: wb_we && wb_addr!=0.
  - The output register loads {wb_addr, wb_data, wb_pc} with RegWrite=1.
  - Every FIFO entry present before this edge with addr==wb_addr has its live bit cleared (kill).
  - An entry pushed at the same edge is younger than the WB write and is not killed.
  - wb_we with wb_addr==0 counts as no WB slot.
- No WB slot and count>0: pop the head.
  - Live head: the output register loads its fields with RegWrite=1.
  - Killed head: pop with RegWrite=0 (one bubble cycle).
- No WB slot and count==0: RegWrite=0; A3, WriteData, and pc hold their previous values.
- Push and pop may occur at the same edge.
  - count +1 for push only, −1 for pop only, unchanged for both.
  - Because mdu_ready uses the registered count, a full FIFO rejects a push even while popping.
- Scoreboard: qN_busy=1 iff qN_addr!=0 and some entry in count range is live with addr==qN_addr. The entry currently in the output register is not busy, because GRF forwards its write internally.

## Timing
- Inputs are sampled at edge t. A3, WriteData, RegWrite, and pc are valid for cycle t+1, and GRF commits at edge t+1. A WB write therefore has a fixed 1-cycle latency.
- MDU latency is 1 cycle plus the queue wait. It is unbounded while WB writes every cycle, so there is no starvation guarantee.
- At most one GRF write per cycle. Order of GRF writes is WB order, interleaved with FIFO order. Kills guarantee that no buffered write overwrites a younger WB write to the same register.
- Reset (asynchronous, any time, including mid-drain):
  - Outputs: A3=0, WriteData=0, RegWrite=0, pc=0.
  - FIFO: count=0, pointers=0, all live=0.
  - Handshakes and query: mdu_ready=1, q*_busy=0.
  - Pending entries are discarded.
- First edge after reset deassertion behaves as normal operation.

## Test plan
- WB only:
  - wb_we=1, wb_addr=5, wb_data=0x1234, wb_pc=0x3000 → next cycle A3=5, WriteData=0x1234, RegWrite=1, pc=0x3000.
  - wb_addr=0 → RegWrite=0.
- MDU drain:
  - Push ($8=0xA, pc 0x3004) with WB idle → RegWrite=1, A3=8 one cycle later.
  - Push during 3 consecutive WB cycles → emitted on the first WB-idle cycle, after the 3 WB writes.
- Full FIFO:
  - Push DEPTH=4 entries while WB writes every cycle → mdu_ready=0, and a 5th offer is not accepted.
  - On the first idle WB cycle → entries pop in order; mdu_ready=1 one cycle after the first pop.
  - Push in the same cycle as the pop while full → rejected.
- Kill:
  - FIFO holds $9=0x1 (live). WB writes $9=0x2 → q1_busy(q1_addr=9) drops the next cycle.
  - Later pop of the killed entry → RegWrite=0 bubble. Final GRF $9 is 0x2.
  - Same-edge MDU push to $9 → not killed; it writes after the WB write.
- Scoreboard: FIFO holds $3 and $7, q1_addr=7, q2_addr=0 → q1_busy=1, q2_busy=0. After $7 pops → q1_busy=0.
- Reset mid-operation: assert reset asynchronously with 3 FIFO entries and RegWrite=1 → RegWrite and all outputs go to 0 immediately, count=0, mdu_ready=1. No buffered write reaches the GRF after release.
